// File: rtl/exec_complete_arbiter.sv
// Collects finish events from the int, load/store and branch units into per-unit FIFOs and
// serialises them round-robin onto one registered completion bus for writeback and PC update.
module exec_complete_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              kill,
  input  logic              stall,
  input  logic [2:0]        unit_valid,
  output logic [2:0]        unit_ready,
  input  logic [2:0]        unit_wen,
  input  logic [14:0]       unit_rd,
  input  logic [3*XLEN-1:0] unit_data,
  input  logic [3*XLEN-1:0] unit_nextpc,
  output logic              cmp_valid,
  output logic [1:0]        cmp_unit,
  output logic              cmp_wen,
  output logic [4:0]        cmp_rd,
  output logic [XLEN-1:0]   cmp_data,
  output logic [XLEN-1:0]   cmp_nextpc
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int EW = 6 + 2 * XLEN;

  typedef logic [EW-1:0] entry_t;

  entry_t        mem      [3][DEPTH];
  entry_t        entry_in [3];
  logic [PW-1:0] wptr     [3];
  logic [PW-1:0] rptr     [3];
  logic [CW-1:0] cnt      [3];

  logic [2:0] push;
  logic [2:0] pop;
  logic [2:0] nonempty;
  logic [1:0] last_grant;
  logic [1:0] grant_idx;
  logic       grant_any;
  logic       advance;
  logic [1:0] order [3];
  entry_t     head;

  // Handshake: unit i transfers an entry on a rising edge where unit_valid[i] and
  // unit_ready[i] are both high; unit_ready depends only on the registered count.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_unit
      assign entry_in[gi]   = {unit_wen[gi], unit_rd[5*gi +: 5],
                               unit_data[XLEN*gi +: XLEN], unit_nextpc[XLEN*gi +: XLEN]};
      assign unit_ready[gi] = (cnt[gi] < CW'(DEPTH));
      assign nonempty[gi]   = (cnt[gi] != '0);
      assign push[gi]       = !kill && unit_valid[gi] && unit_ready[gi];
      assign pop[gi]        = !kill && advance && grant_any && (grant_idx == 2'(gi));

      assert property (@(posedge clk) disable iff (!reset) cnt[gi] <= CW'(DEPTH));
      assert property (@(posedge clk) disable iff (!reset) pop[gi] |-> nonempty[gi]);
    end
  endgenerate

  assign advance = !stall || !cmp_valid;

  // Scan order starts just after the last granted unit.
  always_comb begin
    order[0] = 2'd0;
    order[1] = 2'd1;
    order[2] = 2'd2;
    case (last_grant)
      2'd0: begin order[0] = 2'd1; order[1] = 2'd2; order[2] = 2'd0; end
      2'd1: begin order[0] = 2'd2; order[1] = 2'd0; order[2] = 2'd1; end
      default: ;
    endcase
  end

  always_comb begin
    grant_any = 1'b0;
    grant_idx = 2'd0;
    for (int k = 2; k >= 0; k--) begin
      if (nonempty[order[k]]) begin
        grant_any = 1'b1;
        grant_idx = order[k];
      end
    end
  end

  always_comb begin
    head = mem[0][rptr[0]];
    case (grant_idx)
      2'd1:    head = mem[1][rptr[1]];
      2'd2:    head = mem[2][rptr[2]];
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (push[i]) mem[i][wptr[i]] <= entry_in[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 3; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else if (kill) begin
      for (int i = 0; i < 3; i++) begin
        wptr[i] <= '0;
        rptr[i] <= '0;
        cnt[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (push[i]) wptr[i] <= wptr[i] + PW'(1);
        if (pop[i])  rptr[i] <= rptr[i] + PW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: ;
        endcase
      end
    end
  end

  // Output stage; kill drops cmp_valid but leaves the data fields and last_grant alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cmp_valid  <= 1'b0;
      cmp_unit   <= 2'd0;
      cmp_wen    <= 1'b0;
      cmp_rd     <= 5'd0;
      cmp_data   <= '0;
      cmp_nextpc <= '0;
      last_grant <= 2'd2;
    end else if (kill) begin
      cmp_valid <= 1'b0;
    end else if (advance) begin
      if (grant_any) begin
        cmp_valid  <= 1'b1;
        cmp_unit   <= grant_idx;
        cmp_rd     <= head[EW-2 -: 5];
        cmp_wen    <= head[EW-1] && (head[EW-2 -: 5] != 5'd0);
        cmp_data   <= head[2*XLEN-1 -: XLEN];
        cmp_nextpc <= head[XLEN-1:0];
        last_grant <= grant_idx;
      end else begin
        cmp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/exec_complete_arbiter.md
Name: exec_complete_arbiter

Overview:
- Collects finish events from the three execute units (integer, load/store, branch) and serialises them onto the single completion bus feeding writeback and PC update.
- Each unit gets a small FIFO so a unit can finish while the bus is busy or stalled.
- A round-robin arbiter selects one entry per cycle into a registered completion output stage.
- Sits between the functional units and the complete/writeback logic.

Parameters:
- DEPTH, 2, entries per unit FIFO; power of two, >= 2.
- XLEN, 32, data and PC width.

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-low reset
- kill  input  1  synchronous pipeline flush
- stall  input  1  completion bus cannot accept this cycle
- unit_valid  input  3  finish strobe; bit0 int, bit1 ls, bit2 br
- unit_ready  output  3  FIFO of unit i can accept
- unit_wen  input  3  unit i result writes rd
- unit_rd  input  15  rd of unit i at [5i+4:5i]
- unit_data  input  3*XLEN  result of unit i
- unit_nextpc  input  3*XLEN  next PC of unit i
- cmp_valid  output  1  completion output holds an entry
- cmp_unit  output  2  source unit (0 int, 1 ls, 2 br)
- cmp_wen  output  1  register write enable
- cmp_rd  output  5  destination register
- cmp_data  output  XLEN  result data
- cmp_nextpc  output  XLEN  next PC

Behaviour:
- Reset (async, reset==0): all FIFOs empty, unit_ready=3'b111 once released, cmp_valid=0, cmp_unit=0, cmp_wen=0, cmp_rd=0, cmp_data=0, cmp_nextpc=0, round-robin pointer last_grant=2 (int has first priority).
- Entry = {wen, rd, data, nextpc}. Enqueue on unit i when unit_valid[i] & unit_ready[i] at posedge.
- unit_ready[i] = (count_i < DEPTH), from registered count only. A full FIFO does not accept even if it pops in the same cycle.
- FIFO: read/write pointers of log2(DEPTH) bits that wrap modulo DEPTH; count of log2(DEPTH)+1 bits. Push and pop in the same cycle leave count unchanged.
- Output stage advances when !stall or !cmp_valid.
  - On advance: choose the first non-empty FIFO scanning last_grant+1, +2, +3 (mod 3); pop it; load cmp_* and set cmp_valid=1; update last_grant.
  - If no FIFO is non-empty: cmp_valid<=0.
- stall with cmp_valid=1: cmp_* held bit-stable, no pop.
- Latency: an entry written at edge N is visible to the arbiter after N. Earliest cmp_valid is after edge N+1. There is no same-cycle bypass.
- Throughput: one completion per cycle while !stall.
- Round-robin is applied per grant, so two continuously busy units alternate.
- kill (synchronous) takes priority over everything:
  - all FIFOs emptied and cmp_valid<=0 at that edge;
  - enqueues in the same cycle are dropped;
  - cmp data fields may hold stale values;
  - last_grant is unchanged.
- Reset asserted mid-operation discards all entries immediately (async).
- cmp_wen = stored wen & (rd != 0); an x0 write is never signalled.

Test Plan:
- Int finishes alone, rd=5, data=0x1234, nextpc=0x104, stall=0 -> cmp_valid=1 one cycle after acceptance with cmp_unit=0, cmp_rd=5, cmp_data=0x1234, cmp_wen=1; then cmp_valid=0.
- All three units valid in the same cycle after reset -> completions appear in order int, ls, br on three consecutive cycles. unit_ready stays 3'b111.
- stall=1 for 4 cycles while ls pushes 3 entries (DEPTH=2) -> cmp holds the first entry. unit_ready[1]=0 after the FIFO fills (one in cmp, two in FIFO), and the third push is held by the unit. After stall drops, entries drain in FIFO order.
- Int and br continuously valid -> grants alternate 0,2,0,2. Ls gets a grant within 3 cycles of becoming valid.
- kill while 2 entries are queued and cmp_valid=1 -> next cycle cmp_valid=0 and all unit_ready=1. A push in the kill cycle never appears on cmp.
- Completion with rd=0, wen=1 -> cmp_wen=0, with data and nextpc still delivered.
